// File: rtl/slc3_mem_subsys.sv
`default_nettype none
// ============================================================================
// slc3_mem_subsys : SLC-3 program/data RAM, loaded from an image ROM at reset
// Revision        : 1.0
// ============================================================================
module slc3_mem_subsys #(
  parameter int ADDR_W     = 10,
  parameter int INIT_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic              Ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data
);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FLUSH = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   c_last_cnt = (ADDR_W+1)'(INIT_WORDS - 1);
  localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] c_idx_one  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic              r_ready;
  logic [15:0]       r_dout;
  logic [15:0]       r_mem [0:(2**ADDR_W)-1];

  logic              w_in_range;
  logic [ADDR_W-1:0] w_cpu_idx;
  logic              w_cpu_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [15:0]       w_mem_wdata;
  logic [15:0]       w_rd_data;

  // Upper address bits must be zero; they never fold into the index.
  assign w_in_range = ((ADDR >> ADDR_W) == 16'd0);
  assign w_cpu_idx  = ADDR[ADDR_W-1:0];
  assign w_cpu_en   = (r_state == S_READY);

  assign rom_addr       = r_cnt[ADDR_W-1:0];
  assign Ready          = r_ready;
  assign Data_from_SRAM = r_dout;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Single write port: the ROM copy owns it during init, the CPU afterwards.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    case (r_state)
      S_FILL: begin
        if (r_cnt != '0) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = r_cnt[ADDR_W-1:0] - c_idx_one;
          w_mem_wdata = rom_data;
        end
        if (r_cnt == c_last_cnt) begin
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        w_mem_we    = 1'b1;
        w_mem_waddr = c_last_cnt[ADDR_W-1:0];
        w_mem_wdata = rom_data;
        w_state_nxt = S_READY;
      end
      S_READY: begin
        if (WE && w_in_range) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = w_cpu_idx;
          w_mem_wdata = Data_to_SRAM;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_comb begin
    w_rd_data = 16'h0000;
    if (w_in_range) begin
      w_rd_data = WE ? Data_to_SRAM : r_mem[w_cpu_idx];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_dout  <= 16'h0000;
    end else begin
      if (r_state == S_FILL) begin
        r_cnt <= r_cnt + c_cnt_one;
      end
      if (r_state == S_FLUSH) begin
        r_ready <= 1'b1;
      end
      if (w_cpu_en && OE) begin
        r_dout <= w_rd_data;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_slc3_mem_subsys.sv
`default_nettype none
// ============================================================================
// tb_slc3_mem_subsys : scoreboard bench for slc3_mem_subsys (ADDR_W=4, 4 words)
// Revision           : 1.0
// ============================================================================
module tb_slc3_mem_subsys;

  localparam int ADDR_W     = 4;
  localparam int INIT_WORDS = 4;

  logic              clk;
  logic              reset_n;
  logic [15:0]       addr;
  logic              oe;
  logic              we;
  logic [15:0]       din;
  logic [15:0]       dout;
  logic              ready;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic [15:0]       rom_base;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  slc3_mem_subsys #(.ADDR_W(ADDR_W), .INIT_WORDS(INIT_WORDS)) dut (
    .Clk            (clk),
    .Reset          (reset_n),
    .ADDR           (addr),
    .OE             (oe),
    .WE             (we),
    .Data_to_SRAM   (din),
    .Data_from_SRAM (dout),
    .Ready          (ready),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous image ROM: word = base + address, one cycle late.
  always @(posedge clk) rom_data <= rom_base + {{(16-ADDR_W){1'b0}}, rom_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rom_base = 16'h1000;
    addr = 16'h0; oe = 1'b0; we = 1'b0; din = 16'h0;
    step();
    step();
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b want 0", ready);
    end
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL reset_dout got %h want 0000", dout);
    end
    checks++;
    if (rom_addr !== 4'd0) begin
      errors++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr);
    end
  endtask

  // Releases reset and walks the 5 init edges while the CPU tries to write.
  task automatic test_init_gating();
    reset_n = 1'b1;
    addr = 16'h0002; din = 16'hDEAD; we = 1'b1; oe = 1'b1;
    for (int e = 1; e <= INIT_WORDS + 1; e++) begin
      if (e <= INIT_WORDS) begin
        checks++;
        if (rom_addr !== 4'(e - 1)) begin
          errors++; $display("FAIL init_rom_addr edge %0d got %0d want %0d", e, rom_addr, e - 1);
        end
      end
      step();
      checks++;
      if (ready !== (e == INIT_WORDS + 1)) begin
        errors++; $display("FAIL init_ready after edge %0d got %b want %b", e, ready, e == INIT_WORDS + 1);
      end
      checks++;
      if (dout !== 16'h0000) begin
        errors++; $display("FAIL gated_dout after edge %0d got %h want 0000", e, dout);
      end
    end
    we = 1'b0; oe = 1'b0;
  endtask

  task automatic test_image_read(input logic [15:0] base);
    for (int a = 0; a < INIT_WORDS; a++) begin
      addr = 16'(a); oe = 1'b1; we = 1'b0;
      exp_q.push_back(base + 16'(a));
      step();
      checks++;
      if (dout !== exp_q[0]) begin
        errors++; $display("FAIL image_read addr %0d got %h want %h", a, dout, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    oe = 1'b0;
  endtask

  task automatic test_write_read();
    addr = 16'h0006; din = 16'h6666; we = 1'b1; oe = 1'b0;
    step();
    addr = 16'h0005; din = 16'hBEEF; we = 1'b1;
    step();
    we = 1'b0; oe = 1'b1;
    exp_q.push_back(16'hBEEF);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL write_read got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    addr = 16'h0006;
    exp_q.push_back(16'h6666);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL neighbour_read got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    oe = 1'b0; addr = 16'h0005;
    step();
    checks++;
    if (dout !== 16'h6666) begin
      errors++; $display("FAIL oe_low_hold got %h want 6666", dout);
    end
  endtask

  task automatic test_out_of_range();
    addr = 16'h0013; din = 16'hAAAA; we = 1'b1; oe = 1'b0;
    step();
    we = 1'b0; oe = 1'b1;
    exp_q.push_back(16'h0000);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL oor_read got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    addr = 16'h0003;
    exp_q.push_back(16'h1003);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL oor_alias got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    addr = 16'h8003; din = 16'h5555; we = 1'b1; oe = 1'b1;
    exp_q.push_back(16'h0000);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL oor_rw got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    we = 1'b0; oe = 1'b0;
  endtask

  task automatic test_simultaneous();
    addr = 16'h0003; din = 16'h1234; we = 1'b1; oe = 1'b1;
    exp_q.push_back(16'h1234);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL rw_same_edge got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    we = 1'b0; oe = 1'b1; addr = 16'h0000;
    exp_q.push_back(16'h1000);
    step();
    void'(exp_q.pop_front());
    addr = 16'h0003;
    exp_q.push_back(16'h1234);
    step();
    checks++;
    if (dout !== exp_q[0]) begin
      errors++; $display("FAIL rw_reread got %h want %h", dout, exp_q[0]);
    end
    void'(exp_q.pop_front());
    oe = 1'b0;
  endtask

  task automatic test_reset_mid_init();
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL async_ready got %b want 0", ready);
    end
    checks++;
    if (dout !== 16'h0000) begin
      errors++; $display("FAIL async_dout got %h want 0000", dout);
    end
    step();
    reset_n = 1'b1;
    step();
    step();
    checks++;
    if (rom_addr !== 4'd2) begin
      errors++; $display("FAIL mid_init_cnt got %0d want 2", rom_addr);
    end
    #2;
    reset_n = 1'b0;
    rom_base = 16'h2000;
    step();
    reset_n = 1'b1;
    for (int e = 1; e <= INIT_WORDS + 1; e++) begin
      step();
      checks++;
      if (ready !== (e == INIT_WORDS + 1)) begin
        errors++; $display("FAIL restart_ready after edge %0d got %b want %b", e, ready, e == INIT_WORDS + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_image_read(16'h1000);
    test_write_read();
    test_out_of_range();
    test_simultaneous();
    test_reset_mid_init();
    test_image_read(16'h2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/slc3_mem_subsys.md
Name: slc3_mem_subsys

Overview:
- Synchronous word-addressed program/data memory. Sits directly downstream of the SLC-3 core's external memory bus: consumes ADDR, OE, WE and Data_to_SRAM, and produces Data_from_SRAM.
- After reset, an init FSM copies a program image from an external synchronous ROM into RAM before any CPU access is honoured.
- Ready gates the core: top-level holds the core in reset until Ready=1.

Parameters:
- ADDR_W, 10, implemented address bits; depth = 2**ADDR_W words of 16 bits.
- INIT_WORDS, 256, number of ROM words copied at init; range 1..2**ADDR_W.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = in reset).
- ADDR  input  16  CPU word address (driven from MAR).
- OE  input  1  CPU read enable, active-high.
- WE  input  1  CPU write enable, active-high.
- Data_to_SRAM  input  16  CPU write data.
- Data_from_SRAM  output  16  registered read data to CPU.
- Ready  output  1  init complete; CPU accesses honoured only when 1.
- rom_addr  output  ADDR_W  image ROM address.
- rom_data  input  16  image ROM data, valid one cycle after rom_addr (synchronous ROM).

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=FILL, cnt=0, Ready=0, Data_from_SRAM=0x0000, rom_addr=0.
  - RAM contents are not cleared.
- States FILL -> FLUSH -> READY. No other transitions except reset, which can occur from any state, including mid-init.
- rom_addr = cnt[ADDR_W-1:0] combinationally. It is held at its last value outside FILL.
- FILL:
  - Each edge: if cnt>0, mem[cnt-1] <= rom_data; then cnt <= cnt+1.
  - When cnt==INIT_WORDS-1 at an edge, go to FLUSH.
- FLUSH: one edge writes mem[INIT_WORDS-1] <= rom_data, go to READY, Ready <= 1.
- Ready timing: Ready rises at the (INIT_WORDS+1)th rising edge after Reset deasserts. It stays 1 until the next reset.
- While Ready=0:
  - OE/WE are ignored and no CPU writes occur.
  - Data_from_SRAM is held at 0x0000.
- READY, address decode:
  - In range when ADDR[15:ADDR_W]==0; index = ADDR[ADDR_W-1:0].
- READY, write:
  - On an edge with WE=1 and in range, mem[index] <= Data_to_SRAM.
  - Out-of-range writes are dropped silently.
- READY, read (latency 1):
  - On an edge with OE=1, Data_from_SRAM <= mem[index], or 0x0000 if out of range.
  - When OE=0, Data_from_SRAM holds its previous value.
- READY, OE=1 and WE=1 on the same edge:
  - Write-first: Data_from_SRAM <= Data_to_SRAM (when in range), and the memory is written.
  - Out of range: Data_from_SRAM <= 0x0000 and no write.
- Back-to-back accesses, one per cycle, are supported with no stall. A read after a write to the same address on the next edge returns the new data.
- Reset mid-FILL: the init restarts from cnt=0 on deassertion. Partially written words are overwritten by the restarted copy.
- Width rules:
  - cnt is ADDR_W+1 bits, so INIT_WORDS = 2**ADDR_W does not wrap.
  - Upper ADDR bits above ADDR_W are never truncated into the index.
- Memory is inferable as single-port synchronous block RAM: one write port and one registered read. The init path and the CPU path are muxed onto the same port by state.

Test Plan:
- Init timing:
  - Setup: ADDR_W=4, INIT_WORDS=4, ROM returns 0x1000+addr one cycle late; release Reset.
  - Required: rom_addr steps 0,1,2,3; Ready=0 for 4 edges and 1 after the 5th edge.
  - Then OE=1 reading ADDR 0..3 returns 0x1000..0x1003, one cycle after each request.
- Access gating before Ready:
  - Stimulus: during FILL, WE=1, ADDR=2, Data_to_SRAM=0xDEAD, with OE=1.
  - Required: Data_from_SRAM stays 0x0000; after Ready, reading ADDR 2 returns 0x1002.
- Write then read:
  - Stimulus: after Ready, WE=1 at ADDR 5 with 0xBEEF; next cycle OE=1 at ADDR 5.
  - Required: Data_from_SRAM=0xBEEF one edge later. Reading ADDR 6 (never initialised beyond image) afterwards returns whatever is stored at index 6, unchanged by the write.
- Simultaneous OE and WE:
  - Stimulus: OE=WE=1, ADDR 3, data 0x1234.
  - Required: Data_from_SRAM=0x1234 after that edge, and a later read of ADDR 3 also returns 0x1234.
- Out of range (ADDR_W=4):
  - Stimulus: WE=1 at ADDR 0x0013 with 0xAAAA, then OE=1 at 0x0013, then OE=1 at 0x0003.
  - Required: 0x0000, then 0x1003 (no aliasing).
- Reset mid-init:
  - Stimulus: assert Reset for 1 cycle at cnt=2; ROM now returns 0x2000+addr.
  - Required: Ready drops to 0 and Data_from_SRAM=0 immediately (asynchronous). Ready returns 5 edges after release, and ADDR 0..3 read 0x2000..0x2003.
